banco_registradores: RTL and testbench
======================================

Name: banco_registradores

Overview:
- 16-entry × 8-bit register file for the nRisc processor datapath.
- Two combinational read ports and one synchronous write port.
- A dedicated always-visible output exposes register a0, for I/O and debug.
- Sits between instruction decode (register indices) and the ULA / writeback mux.

Parameters:
- DATA_WIDTH, 8, width of each register and of all data ports
- ADDR_WIDTH, 4, register index width; register count = 2**ADDR_WIDTH (16)
- A0_INDEX, 1, index of the register driven onto Dadoa0

Ports:
- clock  input  1  system clock; all writes on rising edge
- reset  input  1  asynchronous, active-low reset; clears all registers
- RegLido1  input  ADDR_WIDTH  index for read port 1
- RegLido2  input  ADDR_WIDTH  index for read port 2
- RegEscrito  input  ADDR_WIDTH  index for the write port
- DadoEscrito  input  DATA_WIDTH  write data
- EscReg  input  1  write enable, active-high
- DadoLido1  output  DATA_WIDTH  contents of register RegLido1
- DadoLido2  output  DATA_WIDTH  contents of register RegLido2
- Dadoa0  output  DATA_WIDTH  contents of register A0_INDEX

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits.
- Register 0 is hardwired zero:
  - reads of index 0 always return 0
  - writes to index 0 are discarded
- Reset:
  - reset=0 asynchronously forces every register to 0, independent of clock
  - while reset=0 all outputs read 0 and writes are blocked
  - Writes resume on the first rising clock edge after reset returns to 1.
- Write:
  - on a rising clock edge with reset=1, EscReg=1 and RegEscrito≠0, register[RegEscrito] ← DadoEscrito
  - EscReg=0 leaves every register unchanged
- Read:
  - DadoLido1 = register[RegLido1] and DadoLido2 = register[RegLido2]
  - purely combinational; zero cycles of latency from an index change
- Dadoa0:
  - continuously reflects register[A0_INDEX], combinationally
  - updates immediately after the edge that writes A0_INDEX
- Read-during-write, same index, same cycle:
  - no internal forwarding
  - before the edge the read port shows the old value; after the edge it shows the new value
- Multi-port reads:
  - both read ports may address the same register simultaneously; both return identical data
  - read ports may also address A0_INDEX and then match Dadoa0
- No illegal index exists; all 16 indices are valid.
- Outputs never present X after reset has been asserted once.

Test Plan:
- Reset: write 8'hAA to r5, pulse reset=0 mid-cycle (not on an edge) → r5, DadoLido1 (RegLido1=5) and Dadoa0 read 8'h00 immediately, without waiting for a clock edge.
- Basic write/read:
  - EscReg=1, RegEscrito=3, DadoEscrito=8'h5C, one edge → RegLido1=3 gives 8'h5C.
  - RegLido2=3 simultaneously gives 8'h5C.
- Write enable off: EscReg=0, RegEscrito=7, DadoEscrito=8'hFF, one edge → r7 still 8'h00.
- Zero register: EscReg=1, RegEscrito=0, DadoEscrito=8'h12 → RegLido1=0 reads 8'h00.
- a0 output:
  - write 8'h2A to r1 → Dadoa0=8'h2A right after the edge.
  - a subsequent write of 8'h33 to r2 → Dadoa0 stays 8'h2A.
- Read-during-write: r4=8'h10, RegLido1=4, write 8'h20 to r4 → DadoLido1=8'h10 before the edge, 8'h20 after.
- Full sweep: write value (i*17)&8'hFF to r1..r15 → each reads back correctly on both ports; r0 reads 0.

Source files
------------

// File: rtl/banco_registradores.sv
// nRisc register file: 16 x 8-bit, two combinational reads, one write.
// Register 0 is hardwired zero; register A0_INDEX is mirrored on Dadoa0.
module banco_registradores #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int A0_INDEX   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] RegLido1,
    input  logic [ADDR_WIDTH-1:0] RegLido2,
    input  logic [ADDR_WIDTH-1:0] RegEscrito,
    input  logic [DATA_WIDTH-1:0] DadoEscrito,
    input  logic                  EscReg,
    output logic [DATA_WIDTH-1:0] DadoLido1,
    output logic [DATA_WIDTH-1:0] DadoLido2,
    output logic [DATA_WIDTH-1:0] Dadoa0
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]       wr_sel;

    // One-hot write select; entry 0 never selected so it stays zero.
    always_comb begin
        wr_sel = '0;
        for (int i = 1; i < NREG; i++) begin
            wr_sel[i] = EscReg && (RegEscrito == ADDR_WIDTH'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_sel[i]) begin
                regs_d[i] = DadoEscrito;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        DadoLido1 = '0;
        DadoLido2 = '0;
        if (RegLido1 != '0) begin
            DadoLido1 = regs_q[RegLido1];
        end
        if (RegLido2 != '0) begin
            DadoLido2 = regs_q[RegLido2];
        end
    end

    if (A0_INDEX == 0) begin : g_a0_zero
        assign Dadoa0 = '0;
    end else begin : g_a0_reg
        assign Dadoa0 = regs_q[A0_INDEX];
    end

endmodule

// File: tb/tb_banco_registradores.sv
// Scoreboard bench for banco_registradores: directed writes and reads,
// expected values queued by stimulus, checked by a separate monitor.
module tb_banco_registradores;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] RegLido1 = '0;
    logic [3:0] RegLido2 = '0;
    logic [3:0] RegEscrito = '0;
    logic [7:0] DadoEscrito = '0;
    logic       EscReg = 1'b0;
    logic [7:0] DadoLido1;
    logic [7:0] DadoLido2;
    logic [7:0] Dadoa0;

    banco_registradores dut (
        .clock      (clock),
        .reset      (reset),
        .RegLido1   (RegLido1),
        .RegLido2   (RegLido2),
        .RegEscrito (RegEscrito),
        .DadoEscrito(DadoEscrito),
        .EscReg     (EscReg),
        .DadoLido1  (DadoLido1),
        .DadoLido2  (DadoLido2),
        .Dadoa0     (Dadoa0)
    );

    always #5 clock = ~clock;

    typedef struct {
        int       port;
        logic [7:0] exp;
        string    name;
    } item_t;

    item_t q[$];
    event  mon_ev;
    int    n_vec = 0;
    int    n_bad = 0;

    // Monitor: compares every queued expectation when a sample is presented.
    initial begin
        item_t it;
        logic [7:0] act;
        forever begin
            @(mon_ev);
            while (q.size() > 0) begin
                it = q.pop_front();
                case (it.port)
                    0:       act = DadoLido1;
                    1:       act = DadoLido2;
                    default: act = Dadoa0;
                endcase
                n_vec++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h",
                             it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_rd(input int port, input logic [3:0] idx,
                             input logic [7:0] exp, input string name);
        item_t it;
        if (port == 0) RegLido1 = idx;
        if (port == 1) RegLido2 = idx;
        it.port = port;
        it.exp  = exp;
        it.name = name;
        q.push_back(it);
    endtask

    task automatic sample();
        #1;
        ->mon_ev;
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL monitor_timeout: %0d pending, expected 0",
                     q.size());
            q.delete();
        end
    endtask

    task automatic wr(input logic [3:0] idx, input logic [7:0] d,
                      input logic en);
        RegEscrito  = idx;
        DadoEscrito = d;
        EscReg      = en;
        @(posedge clock);
        #1;
        EscReg = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        repeat (2) @(posedge clock);
        #1;
        expect_rd(0, 4'd5, 8'h00, "reset_r5");
        expect_rd(2, 4'd0, 8'h00, "reset_a0");
        sample();
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Mid-cycle asynchronous reset clears contents immediately.
        wr(4'd5, 8'hAA, 1'b1);
        wr(4'd1, 8'h77, 1'b1);
        expect_rd(0, 4'd5, 8'hAA, "pre_reset_r5");
        expect_rd(2, 4'd0, 8'h77, "pre_reset_a0");
        sample();
        #1;
        reset = 1'b0;
        #1;
        expect_rd(0, 4'd5, 8'h00, "async_reset_r5");
        expect_rd(1, 4'd5, 8'h00, "async_reset_r5_p2");
        expect_rd(2, 4'd0, 8'h00, "async_reset_a0");
        sample();
        wr(4'd6, 8'h66, 1'b1);
        expect_rd(0, 4'd6, 8'h00, "write_blocked_in_reset");
        sample();
        #1;
        reset = 1'b1;
        wr(4'd6, 8'h66, 1'b1);
        expect_rd(0, 4'd6, 8'h66, "write_after_reset");
        sample();

        wr(4'd3, 8'h5C, 1'b1);
        expect_rd(0, 4'd3, 8'h5C, "basic_p1");
        expect_rd(1, 4'd3, 8'h5C, "basic_p2");
        sample();

        wr(4'd7, 8'hFF, 1'b0);
        expect_rd(0, 4'd7, 8'h00, "wen_off");
        sample();

        wr(4'd0, 8'h12, 1'b1);
        expect_rd(0, 4'd0, 8'h00, "r0_p1");
        expect_rd(1, 4'd0, 8'h00, "r0_p2");
        sample();

        wr(4'd1, 8'h2A, 1'b1);
        expect_rd(2, 4'd0, 8'h2A, "a0_write");
        expect_rd(0, 4'd1, 8'h2A, "a0_via_p1");
        sample();
        wr(4'd2, 8'h33, 1'b1);
        expect_rd(2, 4'd0, 8'h2A, "a0_unchanged");
        expect_rd(1, 4'd2, 8'h33, "r2_readback");
        sample();

        // Read during write: old value before the edge, new after.
        wr(4'd4, 8'h10, 1'b1);
        RegEscrito  = 4'd4;
        DadoEscrito = 8'h20;
        EscReg      = 1'b1;
        expect_rd(0, 4'd4, 8'h10, "rdw_before");
        sample();
        @(posedge clock);
        #1;
        EscReg = 1'b0;
        expect_rd(0, 4'd4, 8'h20, "rdw_after");
        sample();

        for (int i = 1; i < 16; i++) begin
            v = 8'((i * 17) & 8'hFF);
            wr(4'(i), v, 1'b1);
        end
        for (int i = 1; i < 16; i++) begin
            v = 8'((i * 17) & 8'hFF);
            expect_rd(0, 4'(i), v, $sformatf("sweep_p1_r%0d", i));
            expect_rd(1, 4'(i), v, $sformatf("sweep_p2_r%0d", i));
            sample();
        end
        expect_rd(0, 4'd0, 8'h00, "sweep_r0_p1");
        expect_rd(1, 4'd0, 8'h00, "sweep_r0_p2");
        expect_rd(2, 4'd0, 8'h11, "sweep_a0");
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
